// File: rtl/gray_bcd_display_if.sv
// Switch/display bundle for gray_bcd_display.
// master drives the switch code, slave drives LEDs and display.
interface gray_bcd_display_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic [WIDTH-1:0]  codigo_i;
  logic              mode_i;
  logic [WIDTH-1:0]  codigo_led;
  logic [DIGITS-1:0] anodo;
  logic [6:0]        catodo;
  logic              busy_o;
  logic              done_o;

  modport master (
    output codigo_i, mode_i,
    input  codigo_led, anodo, catodo,
    input  busy_o, done_o
  );

  modport slave (
    input  codigo_i, mode_i,
    output codigo_led, anodo, catodo,
    output busy_o, done_o
  );
endinterface

// File: rtl/gray_bcd_display.sv
// Gray<->binary converter with serial double-dabble BCD
// and a multiplexed common-anode 7-segment display.
module gray_bcd_display #(
  parameter int WIDTH        = 8,
  parameter int DIGITS       = 3,
  parameter int SAMPLE_TICKS = 13500000,
  parameter int SCAN_TICKS   = 27000,
  parameter int BLANK_LZ     = 1
) (
  input logic clk_i,
  input logic rst_i,
  gray_bcd_display_if.slave bus
);

  localparam int SW = $clog2(SAMPLE_TICKS);
  localparam int CW =
    (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int IW =
    (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int NW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t state, state_n;

  logic [SW-1:0]    samp_cnt;
  logic             strobe;
  logic [WIDTH-1:0] conv;
  logic [WIDTH-1:0] conv_r;
  logic [WIDTH-1:0] shift_r;
  logic [BW-1:0]    bcd_r;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    disp_r;
  logic [NW-1:0]    iter;
  logic             done_r;
  logic [CW-1:0]    scan_cnt;
  logic [IW-1:0]    idx;
  logic [DIGITS-1:0] zero_up;
  logic             run;
  logic             sel_zero;
  logic [3:0]       nib;
  logic [6:0]       seg;

  assign strobe = (samp_cnt == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      samp_cnt <= SW'(SAMPLE_TICKS - 1);
    end else if (strobe) begin
      samp_cnt <= SW'(SAMPLE_TICKS - 1);
    end else begin
      samp_cnt <= samp_cnt - 1'b1;
    end
  end

  // Gray->binary bit i is the XOR of all code bits at or above i.
  always_comb begin
    conv = bus.codigo_i ^ (bus.codigo_i >> 1);
    if (bus.mode_i) begin
      for (int i = 0; i < WIDTH; i++) begin
        conv[i] = ^(bus.codigo_i >> i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (strobe) state_n = CONV;
      CONV: if (iter == NW'(1)) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    adj = bcd_r;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_r[4*d +: 4] >= 4'd5) begin
        adj[4*d +: 4] = bcd_r[4*d +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conv_r  <= '0;
      shift_r <= '0;
      bcd_r   <= '0;
      iter    <= '0;
      disp_r  <= '0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (strobe) begin
            conv_r  <= conv;
            shift_r <= conv;
            bcd_r   <= '0;
            iter    <= NW'(WIDTH);
          end
        end
        CONV: begin
          bcd_r   <= {adj[BW-2:0], shift_r[WIDTH-1]};
          shift_r <= shift_r << 1;
          iter    <= iter - 1'b1;
        end
        DONE: begin
          disp_r <= bcd_r;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_cnt <= CW'(SCAN_TICKS - 1);
      idx      <= '0;
    end else if (scan_cnt == '0) begin
      scan_cnt <= CW'(SCAN_TICKS - 1);
      if (idx == IW'(DIGITS - 1)) idx <= '0;
      else                        idx <= idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt - 1'b1;
    end
  end

  // zero_up[d]: digits d..DIGITS-1 are all zero.
  always_comb begin
    run     = 1'b1;
    zero_up = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      run        = run & (disp_r[4*d +: 4] == 4'd0);
      zero_up[d] = run;
    end
  end

  always_comb begin
    nib      = 4'd0;
    sel_zero = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (idx == IW'(d)) begin
        nib      = disp_r[4*d +: 4];
        sel_zero = zero_up[d];
      end
    end
  end

  always_comb begin
    unique case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

  assign bus.catodo =
    ((BLANK_LZ != 0) && (idx != '0) && sel_zero)
    ? 7'b1111111 : seg;
  assign bus.anodo      = ~(DIGITS'(1) << idx);
  assign bus.codigo_led = ~conv_r;
  assign bus.busy_o     = (state != IDLE);
  assign bus.done_o     = done_r;

endmodule

// File: tb/tb_gray_bcd_display.sv
// Directed bench for gray_bcd_display: conversion, BCD,
// scan, blanking, reset abort, back-to-back and 4-bit sweep.
module tb_gray_bcd_display;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] code  = 8'd0;
  logic       mode  = 1'b0;
  logic [7:0] code2 = 8'd0;
  logic       mode2 = 1'b0;
  logic [3:0] code3 = 4'd0;
  logic       mode3 = 1'b0;

  gray_bcd_display_if #(.WIDTH(8), .DIGITS(3)) b0 ();
  gray_bcd_display_if #(.WIDTH(8), .DIGITS(3)) b1 ();
  gray_bcd_display_if #(.WIDTH(8), .DIGITS(3)) b2 ();
  gray_bcd_display_if #(.WIDTH(4), .DIGITS(2)) b3 ();

  assign b0.codigo_i = code;
  assign b0.mode_i   = mode;
  assign b1.codigo_i = code;
  assign b1.mode_i   = mode;
  assign b2.codigo_i = code2;
  assign b2.mode_i   = mode2;
  assign b3.codigo_i = code3;
  assign b3.mode_i   = mode3;

  gray_bcd_display #(
    .WIDTH(8), .DIGITS(3), .SAMPLE_TICKS(20),
    .SCAN_TICKS(2), .BLANK_LZ(1)
  ) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));

  gray_bcd_display #(
    .WIDTH(8), .DIGITS(3), .SAMPLE_TICKS(20),
    .SCAN_TICKS(2), .BLANK_LZ(0)
  ) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));

  gray_bcd_display #(
    .WIDTH(8), .DIGITS(3), .SAMPLE_TICKS(11),
    .SCAN_TICKS(1), .BLANK_LZ(1)
  ) u2 (.clk_i(clk), .rst_i(rst), .bus(b2));

  gray_bcd_display #(
    .WIDTH(4), .DIGITS(2), .SAMPLE_TICKS(7),
    .SCAN_TICKS(1), .BLANK_LZ(1)
  ) u3 (.clk_i(clk), .rst_i(rst), .bus(b3));

  function automatic logic [15:0] b2g(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [15:0] g2b(
    input logic [15:0] g, input int w);
    logic [15:0] b;
    b = '0;
    b[w-1] = g[w-1];
    for (int i = w - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [11:0] bcd3(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic wait_rise0(output bit ok);
    int n = 0;
    while (b0.busy_o && n < 60) begin
      @(negedge clk); n++;
    end
    while (!b0.busy_o && n < 60) begin
      @(negedge clk); n++;
    end
    ok = b0.busy_o && (n < 60);
  endtask

  task automatic wait_rise3(output bit ok);
    int n = 0;
    while (b3.busy_o && n < 40) begin
      @(negedge clk); n++;
    end
    while (!b3.busy_o && n < 40) begin
      @(negedge clk); n++;
    end
    ok = b3.busy_o && (n < 40);
  endtask

  task automatic wait_done0(output int n);
    n = 0;
    while (n < 30) begin
      @(negedge clk); n++;
      if (b0.done_o) break;
    end
  endtask

  task automatic fetch0(
    input int k, output logic [6:0] seg, output bit ok);
    logic [2:0] want;
    want = ~(3'b001 << k);
    ok = 1'b0; seg = 'x;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b0.anodo === want) begin
        ok = 1'b1; seg = b0.catodo; break;
      end
    end
  endtask

  task automatic fetch1(
    input int k, output logic [6:0] seg, output bit ok);
    logic [2:0] want;
    want = ~(3'b001 << k);
    ok = 1'b0; seg = 'x;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b1.anodo === want) begin
        ok = 1'b1; seg = b1.catodo; break;
      end
    end
  endtask

  task automatic fetch3(
    input int k, output logic [6:0] seg, output bit ok);
    logic [1:0] want;
    want = ~(2'b01 << k);
    ok = 1'b0; seg = 'x;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (b3.anodo === want) begin
        ok = 1'b1; seg = b3.catodo; break;
      end
    end
  endtask

  task automatic test_reset;
    int n;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (b0.codigo_led !== 8'hFF || b0.busy_o !== 1'b0 ||
        b0.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_out led=%h busy=%b done=%b want ff/0/0",
               b0.codigo_led, b0.busy_o, b0.done_o);
    end
    checks++;
    if (b0.anodo !== 3'b110 || b0.catodo !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_disp an=%b seg=%b want 110/1000000",
               b0.anodo, b0.catodo);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!b0.busy_o && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL first_strobe got %0d clocks want 20", n);
    end
  endtask

  task automatic test_bin2gray;
    bit ok;
    int n;
    logic [6:0] seg;
    logic [6:0] want [3];
    want = '{7'b0100100, 7'b1111000, 7'b1111001};
    code = 8'd200; mode = 1'b0;
    wait_rise0(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2g_strobe timeout got none want busy");
    end
    checks++;
    if (b0.codigo_led !== 8'h53) begin
      errors++;
      $display("FAIL b2g_led got %h want 53", b0.codigo_led);
    end
    wait_done0(n);
    checks++;
    if (n !== 9) begin
      errors++;
      $display("FAIL b2g_latency got %0d want 9", n);
    end
    @(negedge clk);
    checks++;
    if (b0.done_o !== 1'b0 || b0.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL b2g_pulse done=%b busy=%b want 0/0",
               b0.done_o, b0.busy_o);
    end
    for (int k = 0; k < 3; k++) begin
      fetch0(k, seg, ok);
      checks++;
      if (!ok || seg !== want[k]) begin
        errors++;
        $display("FAIL b2g_digit%0d got %b want %b",
                 k, seg, want[k]);
      end
    end
  endtask

  task automatic test_gray2bin;
    bit ok;
    int n;
    logic [6:0] seg;
    logic [6:0] want [3];
    want = '{7'b1000000, 7'b1000000, 7'b0100100};
    code = 8'hAC; mode = 1'b1;
    wait_rise0(ok);
    checks++;
    if (!ok || b0.codigo_led !== 8'h37) begin
      errors++;
      $display("FAIL g2b_led got %h want 37", b0.codigo_led);
    end
    wait_done0(n);
    for (int k = 0; k < 3; k++) begin
      fetch0(k, seg, ok);
      checks++;
      if (!ok || seg !== want[k]) begin
        errors++;
        $display("FAIL g2b_digit%0d got %b want %b",
                 k, seg, want[k]);
      end
    end
  endtask

  task automatic test_blanking;
    bit ok;
    int n;
    logic [6:0] seg;
    code = 8'd3; mode = 1'b0;
    wait_rise0(ok);
    checks++;
    if (!ok || b0.codigo_led !== 8'hFD) begin
      errors++;
      $display("FAIL blank_led got %h want fd", b0.codigo_led);
    end
    wait_done0(n);
    fetch0(0, seg, ok);
    checks++;
    if (!ok || seg !== 7'b0100100) begin
      errors++;
      $display("FAIL blank_d0 got %b want 0100100", seg);
    end
    for (int k = 1; k < 3; k++) begin
      fetch0(k, seg, ok);
      checks++;
      if (!ok || seg !== 7'b1111111) begin
        errors++;
        $display("FAIL blank_d%0d got %b want 1111111", k, seg);
      end
      fetch1(k, seg, ok);
      checks++;
      if (!ok || seg !== 7'b1000000) begin
        errors++;
        $display("FAIL noblank_d%0d got %b want 1000000", k, seg);
      end
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    code = 8'd200; mode = 1'b0;
    wait_rise0(ok);
    repeat (3) @(negedge clk);
    checks++;
    if (!b0.busy_o) begin
      errors++;
      $display("FAIL mid_busy got 0 want 1");
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (b0.busy_o !== 1'b0 || b0.codigo_led !== 8'hFF ||
        b0.done_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst busy=%b led=%h done=%b want 0/ff/0",
               b0.busy_o, b0.codigo_led, b0.done_o);
    end
    checks++;
    if (b0.anodo !== 3'b110 || b0.catodo !== 7'b1000000) begin
      errors++;
      $display("FAIL mid_rst_disp an=%b seg=%b want 110/1000000",
               b0.anodo, b0.catodo);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic       prev_busy;
    logic [7:0] pc, ex, pend;
    logic       pm;
    int rises = 0;
    int dones = 0;
    int k = 0;
    prev_busy = b2.busy_o;
    pc = code2; pm = mode2; pend = '0;
    repeat (110) begin
      @(negedge clk);
      if (b2.busy_o && !prev_busy) begin
        rises++;
        ex = pm ? 8'(g2b({8'd0, pc}, 8)) : 8'(b2g({8'd0, pc}));
        pend = ex;
        checks++;
        if (b2.codigo_led !== ~ex) begin
          errors++;
          $display("FAIL b2b_led got %h want %h",
                   b2.codigo_led, ~ex);
        end
      end
      if (b2.done_o) begin
        dones++;
        checks++;
        if (u2.disp_r !== bcd3(int'(pend))) begin
          errors++;
          $display("FAIL b2b_disp got %h want %h",
                   u2.disp_r, bcd3(int'(pend)));
        end
      end
      prev_busy = b2.busy_o;
      code2 = 8'($urandom);
      mode2 = 1'($urandom);
      pc = code2; pm = mode2;
    end
    while (b2.busy_o && k < 20) begin
      @(negedge clk); k++;
      if (b2.done_o) begin
        dones++;
        checks++;
        if (u2.disp_r !== bcd3(int'(pend))) begin
          errors++;
          $display("FAIL b2b_disp got %h want %h",
                   u2.disp_r, bcd3(int'(pend)));
        end
      end
    end
    checks++;
    if (dones !== rises || rises < 8) begin
      errors++;
      $display("FAIL b2b_count dones=%0d want %0d (>=8)",
               dones, rises);
    end
  endtask

  task automatic test_exhaustive;
    bit ok;
    int n;
    int v;
    logic [3:0] ex;
    logic [6:0] seg, want;
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 16; c++) begin
        code3 = 4'(c); mode3 = 1'(m);
        ex = m ? 4'(g2b(16'(c), 4)) : 4'(b2g(16'(c)));
        v = int'(ex);
        wait_rise3(ok);
        checks++;
        if (!ok || b3.codigo_led !== ~ex) begin
          errors++;
          $display("FAIL sweep_led m=%0d c=%0d got %h want %h",
                   m, c, b3.codigo_led, ~ex);
        end
        n = 0;
        while (!b3.done_o && n < 20) begin
          @(negedge clk); n++;
        end
        fetch3(0, seg, ok);
        want = seg7(v % 10);
        checks++;
        if (!ok || seg !== want) begin
          errors++;
          $display("FAIL sweep_units m=%0d c=%0d got %b want %b",
                   m, c, seg, want);
        end
        fetch3(1, seg, ok);
        want = (v / 10 == 0) ? 7'b1111111 : seg7(v / 10);
        checks++;
        if (!ok || seg !== want) begin
          errors++;
          $display("FAIL sweep_tens m=%0d c=%0d got %b want %b",
                   m, c, seg, want);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_bin2gray;
    test_gray2bin;
    test_blanking;
    test_reset_mid;
    test_back_to_back;
    test_exhaustive;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gray_bcd_display.md
# gray_bcd_display

Parametrised successor to the 4-bit Gray decoder/display block. It periodically samples a WIDTH-bit switch code and converts it binary→Gray or Gray→binary, selected at run time. The converted value drives active-low LEDs directly. A sequential double-dabble converter turns it into DIGITS BCD digits, which are time-multiplexed onto a common-anode 7-segment display with optional leading-zero blanking. It sits between the board switch inputs and the display/LED pins.

## Interface
- WIDTH, 8: code width in bits (2..16).
- DIGITS, 3: number of 7-segment digits; must satisfy 10^DIGITS > 2^WIDTH−1.
  - Illegal combinations are a configuration error and are not handled.
- SAMPLE_TICKS, 13500000: clocks per input sample strobe (≥ WIDTH+3).
- SCAN_TICKS, 27000: clocks per digit scan step (≥1).
- BLANK_LZ, 1: 1 = blank leading zero digits.
- clk_i  in  1  system clock; the only clock.
- rst_i  in  1  reset, asynchronous, active-high.
- codigo_i  in  WIDTH  raw switch code.
- mode_i  in  1  0 = binary→Gray, 1 = Gray→binary.
- codigo_led  out  WIDTH  ~conv_r (active-low LEDs).
- anodo  out  DIGITS  one-hot-low digit enable.
- catodo  out  7  active-low segments {g,f,e,d,c,b,a}.
- busy_o  out  1  high while a conversion is in progress.
- done_o  out  1  one-cycle pulse when the display value updates.

## Operation
- Sample counter:
  - Reset value SAMPLE_TICKS−1; decrements each clock; reloads from 0.
  - strobe = (count == 0), so there is one strobe every SAMPLE_TICKS clocks.
- Conversion, combinational from codigo_i/mode_i:
  - mode 0: g = b ^ (b>>1).
  - mode 1: b[W−1] = g[W−1]; b[i] = b[i+1] ^ g[i].
- FSM states IDLE, CONV, DONE:
  - IDLE + strobe:
    - Register the converted value into conv_r.
    - Load shift_r ← the same value and clear bcd_r (4·DIGITS bits).
    - Set iter ← WIDTH and go to CONV.
  - CONV, each cycle:
    - Every bcd_r nibble ≥5 gets +3.
    - Then {bcd_r, shift_r} shifts left by 1.
    - iter decrements; when iter reaches 1 (last shift), go to DONE.
  - DONE: disp_r ← bcd_r; done_o = 1; go to IDLE.
  - A strobe in CONV or DONE is dropped. It is not queued, and conv_r is not changed.
- busy_o = (state != IDLE).
- Scan:
  - Counter reloads at SCAN_TICKS−1.
  - On reaching 0, the digit index advances 0,1,…,DIGITS−1,0.
  - anodo[idx] = 0; all other anodo bits = 1.
  - Digit 0 is least significant.
- Segment patterns: 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000.
  - Any other nibble → 1111111.
- Blanking:
  - With BLANK_LZ=1, digit idx>0 shows 1111111 when disp_r digits idx..DIGITS−1 are all zero.
  - Its anode is still driven low.
  - Digit 0 is never blanked.

## Timing
- Reset (async assert; deassert is synchronous to clk_i):
  - State IDLE; counters at TICKS−1; idx = 0.
  - conv_r = 0, so codigo_led = all ones.
  - disp_r = 0, so anodo = ~1 and catodo = 1000000.
  - busy_o = 0, done_o = 0.
- Strobe sampled at edge t:
  - conv_r and codigo_led update at edge t.
  - CONV occupies WIDTH cycles.
  - disp_r updates and done_o rises at edge t+WIDTH+1; done_o is high for one cycle.
- busy_o is high from edge t through edge t+WIDTH+1.
- anodo/catodo are combinational from idx/disp_r. There is no glitch requirement between scan steps.
- Reset mid-conversion aborts immediately. disp_r returns to 0; there is no partial update.
- Mode change takes effect only at the next accepted strobe.

## Test plan
- Reset:
  - Assert rst_i mid-CONV → outputs take reset values within the same cycle (asynchronous).
  - After release, the first strobe occurs after SAMPLE_TICKS clocks.
- Binary→Gray (WIDTH=8, DIGITS=3, mode 0, codigo_i=200):
  - codigo_led = 8'h53 at the strobe edge.
  - done_o pulses 9 cycles later.
  - Scan shows digit0 = 2, digit1 = 7, digit2 = 1 (value 172).
- Gray→binary (mode 1, codigo_i=8'hAC):
  - codigo_led = ~8'd200 = 8'h37.
  - Digits 0, 0, 2 (value 200); the middle zero is not blanked.
- Leading-zero blanking (mode 0, codigo_i=3, so Gray = 2):
  - digit0 = 0100100; digits 1 and 2 = 1111111, with their anodes still asserted.
  - With BLANK_LZ=0, digits 1 and 2 show 1000000.
- Dropped strobe:
  - Use SAMPLE_TICKS=WIDTH+3 and change codigo_i every cycle.
  - Expect exactly one done_o per accepted strobe.
  - disp_r must always equal the BCD of the conv_r captured at that strobe.
- Exhaustive (WIDTH=4, DIGITS=2):
  - Sweep all 16 codes in both modes.
  - The converted value must match a reference model; the displayed tens and units must match its decimal value.
